buf_audio_in_stereo: RTL and testbench

- I2S slave receiver plus per-channel sample FIFOs. Sits between the external audio ADC/codec I2S link and the sys_clk-domain DSP datapath.
- Deserialises 24-bit Philips-I2S stereo words and fans each word out to NUM_AUDIO_CHANNELS stereo pairs of L/R FIFOs.
- Presents every FIFO head in parallel and pops all FIFOs together on a global read strobe.

---
 rtl/buf_audio_in_pkg.sv | 15 +
 rtl/buf_audio_in_stereo_i2s_rx_deser.sv | 70 +++++++
 rtl/buf_audio_in_stereo.sv | 123 ++++++++++++
 tb/tb_buf_audio_in_stereo.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/buf_audio_in_pkg.sv
// buf_audio_in_pkg: shared types, default widths and pointer/count width helpers for buf_audio_in_stereo
package buf_audio_in_pkg;
  localparam int STEREO_MULTIPLIER = 2;
  localparam int DEF_NUM_AUDIO_CHANNELS = 1;
  localparam int DEF_I2S_WIDTH = 24;
  localparam int DEF_AUDIO_WIDTH = 24;
  localparam int DEF_BUFFER_DEPTH = 16;
  typedef enum logic {LEFT = 1'b0, RIGHT = 1'b1} lr_sel_e;
  function automatic int ptr_w(input int depth);
    return $clog2(depth / STEREO_MULTIPLIER);
  endfunction
  function automatic int cnt_w(input int depth);
    return ptr_w(depth) + 1;
  endfunction
endpackage

// File: rtl/buf_audio_in_stereo_i2s_rx_deser.sv
// i2s_rx_deser: synchronises the I2S slave inputs into clk_i and emits one committed word per lrclk change
// Ports: clk_i/rst_ni (async active-low), bclk_i/lrclk_i/data_i raw I2S pins,
//        commit_o one-cycle word strobe, channel_o side the word belongs to, word_o MSB..LSB word,
//        bit_cnt_o (only with BUF_AUDIO_IN_DEBUG_EN) bclk rises since last lrclk change, saturating.
module i2s_rx_deser
  import buf_audio_in_pkg::*;
#(
  parameter int I2S_WIDTH = DEF_I2S_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 bclk_i,
  input  logic                 lrclk_i,
  input  logic                 data_i,
  output logic                 commit_o,
  output lr_sel_e              channel_o,
  output logic [I2S_WIDTH-1:0] word_o
`ifdef BUF_AUDIO_IN_DEBUG_EN
  ,
  output logic [4:0]           bit_cnt_o
`endif
);
  logic [1:0] bclk_q, lr_q, data_q;
  logic bclk_prev_q, lr_prev_q, seen_q, framed_q;
  logic [I2S_WIDTH-1:0] shift_reg, shift_d;
  logic rise, change;
  assign rise = bclk_q[1] & ~bclk_prev_q;
  // seen_q keeps the first rise after reset from counting as an lrclk edge
  assign change = rise & seen_q & (lr_q[1] != lr_prev_q);
  assign shift_d = {shift_reg[I2S_WIDTH-2:0], data_q[1]};
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bclk_q      <= '0;
      lr_q        <= '0;
      data_q      <= '0;
      bclk_prev_q <= 1'b0;
      lr_prev_q   <= 1'b0;
      seen_q      <= 1'b0;
      framed_q    <= 1'b0;
      shift_reg   <= '0;
      commit_o    <= 1'b0;
      channel_o   <= LEFT;
      word_o      <= '0;
    end else begin
      bclk_q      <= {bclk_q[0], bclk_i};
      lr_q        <= {lr_q[0], lrclk_i};
      data_q      <= {data_q[0], data_i};
      bclk_prev_q <= bclk_q[1];
      // the first lrclk edge only frames; the partial word before it is discarded
      commit_o    <= change & framed_q;
      if (rise) begin
        shift_reg <= shift_d;
        lr_prev_q <= lr_q[1];
        seen_q    <= 1'b1;
      end
      if (change) framed_q <= 1'b1;
      if (change & framed_q) begin
        word_o    <= shift_d;
        channel_o <= lr_sel_e'(lr_prev_q);
      end
    end
  end
`ifdef BUF_AUDIO_IN_DEBUG_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) bit_cnt_o <= '0;
    else if (change) bit_cnt_o <= '0;
    else if (rise && bit_cnt_o != 5'd31) bit_cnt_o <= bit_cnt_o + 5'd1;
  end
`endif
endmodule

// File: rtl/buf_audio_in_stereo.sv
// buf_audio_in_stereo: I2S slave receiver feeding NUM_AUDIO_CHANNELS pairs of drop-oldest L/R sample FIFOs
// Ports: sys_clk, sys_rst (async active-low); adv_read_req streaming pop, adv_read_enable single pop;
//        i2s_bclk/i2s_lrclk/i2s_data I2S slave inputs; audio_channel_out registered FIFO heads
//        (2p = pair p Left, 2p+1 = pair p Right); sample_valid per committed word;
//        buffer_ready all FIFOs non-empty; buffer_full all FIFOs at capacity.
// Optional: BUF_AUDIO_IN_DEBUG_EN adds dbg_bit_counter and the sticky dbg_overflow.
module buf_audio_in_stereo
  import buf_audio_in_pkg::*;
#(
  parameter int NUM_AUDIO_CHANNELS = DEF_NUM_AUDIO_CHANNELS,
  parameter int I2S_WIDTH          = DEF_I2S_WIDTH,
  parameter int AUDIO_WIDTH        = DEF_AUDIO_WIDTH,
  parameter int BUFFER_DEPTH       = DEF_BUFFER_DEPTH
) (
  input  logic                                               sys_clk,
  input  logic                                               sys_rst,
  input  logic                                               adv_read_req,
  input  logic                                               adv_read_enable,
  input  logic                                               i2s_bclk,
  input  logic                                               i2s_lrclk,
  input  logic                                               i2s_data,
  output logic [2*NUM_AUDIO_CHANNELS-1:0][AUDIO_WIDTH-1:0]   audio_channel_out,
  output logic                                               sample_valid,
  output logic                                               buffer_ready,
  output logic                                               buffer_full
`ifdef BUF_AUDIO_IN_DEBUG_EN
  ,
  output logic [4:0]                                         dbg_bit_counter,
  output logic                                               dbg_overflow
`endif
);
  localparam int D  = BUFFER_DEPTH / STEREO_MULTIPLIER;
  localparam int PW = ptr_w(BUFFER_DEPTH);
  localparam int CW = cnt_w(BUFFER_DEPTH);
  localparam int M  = 2 * NUM_AUDIO_CHANNELS;
  logic commit, pop;
  lr_sel_e channel;
  logic [I2S_WIDTH-1:0] rx_word;
  logic [AUDIO_WIDTH-1:0] sample;
  logic [PW-1:0] write_ptr [NUM_AUDIO_CHANNELS][2], read_ptr [NUM_AUDIO_CHANNELS][2];
  logic [PW-1:0] wp_d [NUM_AUDIO_CHANNELS][2], rp_d [NUM_AUDIO_CHANNELS][2];
  logic [CW-1:0] buffer_count [NUM_AUDIO_CHANNELS][2], cnt_d [NUM_AUDIO_CHANNELS][2];
  logic [M-1:0] ready_d, full_d;
  i2s_rx_deser #(.I2S_WIDTH(I2S_WIDTH)) u_rx (
    .clk_i     (sys_clk),
    .rst_ni    (sys_rst),
    .bclk_i    (i2s_bclk),
    .lrclk_i   (i2s_lrclk),
    .data_i    (i2s_data),
    .commit_o  (commit),
    .channel_o (channel),
    .word_o    (rx_word)
`ifdef BUF_AUDIO_IN_DEBUG_EN
    ,
    .bit_cnt_o (dbg_bit_counter)
`endif
  );
  if (AUDIO_WIDTH <= I2S_WIDTH) begin : g_trunc
    assign sample = rx_word[I2S_WIDTH-1 -: AUDIO_WIDTH];
  end else begin : g_pad
    assign sample = {rx_word, {(AUDIO_WIDTH - I2S_WIDTH){1'b0}}};
  end
  assign pop = adv_read_enable | (adv_read_req & buffer_ready);
`ifdef BUF_AUDIO_IN_DEBUG_EN
  logic [M-1:0] drop;
`endif
  for (genvar p = 0; p < NUM_AUDIO_CHANNELS; p++) begin : g_pair
    for (genvar s = 0; s < 2; s++) begin : g_side
      logic push, has, full, eff_pop, adv_rd;
      logic [AUDIO_WIDTH-1:0] mem [D];
      logic [AUDIO_WIDTH-1:0] head_q;
      assign push    = commit & (channel == (s == 0 ? LEFT : RIGHT));
      assign has     = buffer_count[p][s] != '0;
      assign full    = buffer_count[p][s] == CW'(D);
      assign eff_pop = pop & has;
      // a push into a full FIFO without a pop drags read_ptr along (drop-oldest)
      assign adv_rd  = eff_pop | (push & full);
      assign wp_d[p][s]  = write_ptr[p][s] + PW'(push);
      assign rp_d[p][s]  = read_ptr[p][s] + PW'(adv_rd);
      assign cnt_d[p][s] = buffer_count[p][s] + CW'(push & ~full & ~eff_pop) - CW'(eff_pop & ~push);
      assign ready_d[2*p+s] = cnt_d[p][s] != '0;
      assign full_d[2*p+s]  = cnt_d[p][s] == CW'(D);
`ifdef BUF_AUDIO_IN_DEBUG_EN
      assign drop[2*p+s] = push & full & ~eff_pop;
`endif
      // head follows the next read pointer, forwarding a same-cycle write to that slot
      always_ff @(posedge sys_clk) begin
        if (push) mem[write_ptr[p][s]] <= sample;
        head_q <= (push && write_ptr[p][s] == rp_d[p][s]) ? sample : mem[rp_d[p][s]];
      end
      assign audio_channel_out[2*p+s] = head_q;
    end
  end
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      for (int i = 0; i < NUM_AUDIO_CHANNELS; i++)
        for (int j = 0; j < 2; j++) begin
          write_ptr[i][j]    <= '0;
          read_ptr[i][j]     <= '0;
          buffer_count[i][j] <= '0;
        end
      sample_valid <= 1'b0;
      buffer_ready <= 1'b0;
      buffer_full  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_AUDIO_CHANNELS; i++)
        for (int j = 0; j < 2; j++) begin
          write_ptr[i][j]    <= wp_d[i][j];
          read_ptr[i][j]     <= rp_d[i][j];
          buffer_count[i][j] <= cnt_d[i][j];
        end
      sample_valid <= commit;
      buffer_ready <= &ready_d;
      buffer_full  <= &full_d;
    end
  end
`ifdef BUF_AUDIO_IN_DEBUG_EN
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) dbg_overflow <= 1'b0;
    else if (|drop) dbg_overflow <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_buf_audio_in_stereo.sv
// tb_buf_audio_in_stereo: directed self-checking bench for buf_audio_in_stereo
module tb_buf_audio_in_stereo;
  logic sys_clk = 1'b0, sys_rst = 1'b0, adv_read_req = 1'b0, adv_read_enable = 1'b0;
  logic i2s_bclk = 1'b0, i2s_lrclk = 1'b0, i2s_data = 1'b0;
  logic [1:0][23:0] audio_channel_out;
  logic sample_valid, buffer_ready, buffer_full;
`ifdef BUF_AUDIO_IN_DEBUG_EN
  logic [4:0] dbg_bit_counter;
  logic dbg_overflow;
`endif
  int checks = 0, failures = 0, sv_total = 0, max_cnt = 0, base;
  bit mon_en = 1'b0, full_seen = 1'b0;
  always #5 sys_clk = ~sys_clk;
  buf_audio_in_stereo dut (
    .sys_clk           (sys_clk),
    .sys_rst           (sys_rst),
    .adv_read_req      (adv_read_req),
    .adv_read_enable   (adv_read_enable),
    .i2s_bclk          (i2s_bclk),
    .i2s_lrclk         (i2s_lrclk),
    .i2s_data          (i2s_data),
    .audio_channel_out (audio_channel_out),
    .sample_valid      (sample_valid),
    .buffer_ready      (buffer_ready),
    .buffer_full       (buffer_full)
`ifdef BUF_AUDIO_IN_DEBUG_EN
    ,
    .dbg_bit_counter   (dbg_bit_counter),
    .dbg_overflow      (dbg_overflow)
`endif
  );
  always @(posedge sys_clk) if (sample_valid) sv_total++;
  always @(negedge sys_clk) if (mon_en) begin
    if (buffer_full) full_seen = 1'b1;
    if (int'(dut.buffer_count[0][0]) > max_cnt) max_cnt = int'(dut.buffer_count[0][0]);
    if (int'(dut.buffer_count[0][1]) > max_cnt) max_cnt = int'(dut.buffer_count[0][1]);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic clks(input int n);
    repeat (n) @(negedge sys_clk);
  endtask
  task automatic do_reset();
    i2s_bclk = 1'b0;
    i2s_lrclk = 1'b0;
    i2s_data = 1'b0;
    clks(2);
    sys_rst = 1'b0;
    clks(3);
    sys_rst = 1'b1;
    clks(2);
  endtask
  task automatic send_bit(input logic lr, input logic d);
    i2s_bclk = 1'b0;
    i2s_lrclk = lr;
    i2s_data = d;
    #50;
    i2s_bclk = 1'b1;
    #50;
  endtask
  // LSB rides on the first bit slot of the opposite lrclk level (1-bit I2S delay)
  task automatic send_word(input logic ch, input logic [23:0] w);
    for (int i = 23; i > 0; i--) send_bit(ch, w[i]);
    send_bit(~ch, w[0]);
  endtask
  task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
    send_word(1'b0, l);
    send_word(1'b1, r);
  endtask
  task automatic preamble();
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
  endtask
  task automatic pop();
    @(negedge sys_clk) adv_read_enable = 1'b1;
    @(negedge sys_clk) adv_read_enable = 1'b0;
  endtask
  initial begin
    do_reset();
    check("rst_ready", buffer_ready, 0);
    check("rst_full", buffer_full, 0);
    check("rst_valid", sample_valid, 0);
    base = sv_total;
    preamble();
    send_frame(24'h123456, 24'hABCDEF);
    clks(10);
    check("f1_valid_pulses", sv_total - base, 2);
    check("f1_ready", buffer_ready, 1);
    check("f1_out_l", audio_channel_out[0], 32'h123456);
    check("f1_out_r", audio_channel_out[1], 32'hABCDEF);
    check("f1_cnt_l", dut.buffer_count[0][0], 1);
    pop();
    clks(1);
    check("f1_ready_after_pop", buffer_ready, 0);
    check("f1_cnt_after_pop", dut.buffer_count[0][1], 0);
    send_frame(24'h0A0A0A, 24'h050505);
    clks(10);
    check("f2_ready", buffer_ready, 1);
    check("f2_wptr", dut.write_ptr[0][0], 2);
    do_reset();
    check("rst2_wptr_l", dut.write_ptr[0][0], 0);
    check("rst2_wptr_r", dut.write_ptr[0][1], 0);
    check("rst2_rptr_l", dut.read_ptr[0][0], 0);
    check("rst2_rptr_r", dut.read_ptr[0][1], 0);
    check("rst2_cnt_l", dut.buffer_count[0][0], 0);
    check("rst2_cnt_r", dut.buffer_count[0][1], 0);
    check("rst2_shift", dut.u_rx.shift_reg, 0);
    check("rst2_ready", buffer_ready, 0);
    check("rst2_full", buffer_full, 0);
    preamble();
    for (int i = 0; i < 8; i++) send_frame(24'h100000 + 24'(i), 24'h200000 + 24'(i));
    clks(10);
    check("fill_full", buffer_full, 1);
    check("fill_ready", buffer_ready, 1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("fill_l%0d", i), audio_channel_out[0], 32'h100000 + i);
      check($sformatf("fill_r%0d", i), audio_channel_out[1], 32'h200000 + i);
      pop();
    end
    clks(1);
    check("drain_ready", buffer_ready, 0);
    check("drain_full", buffer_full, 0);
    for (int i = 0; i < 16; i++) begin
      send_frame(24'h100000 + 24'(i), 24'h200000 + 24'(i));
      if (i >= 7) begin
        clks(10);
        check($sformatf("ovf_cnt_l%0d", i), dut.buffer_count[0][0], 8);
        check($sformatf("ovf_cnt_r%0d", i), dut.buffer_count[0][1], 8);
      end
    end
    send_frame(24'hBEEF01, 24'hBEEF02);
    clks(10);
    check("ovf_cnt_last", dut.buffer_count[0][0], 8);
    check("ovf_full", buffer_full, 1);
`ifdef BUF_AUDIO_IN_DEBUG_EN
    check("ovf_dbg_flag", dbg_overflow, 1);
`endif
    for (int i = 9; i < 16; i++) begin
      check($sformatf("ovf_l%0d", i), audio_channel_out[0], 32'h100000 + i);
      check($sformatf("ovf_r%0d", i), audio_channel_out[1], 32'h200000 + i);
      pop();
    end
    check("ovf_beef_l", audio_channel_out[0], 32'hBEEF01);
    check("ovf_beef_r", audio_channel_out[1], 32'hBEEF02);
    pop();
    clks(1);
    check("ovf_drained", buffer_ready, 0);
    base = sv_total;
    adv_read_req = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) send_frame(24'h300000 + 24'(i), 24'h400000 + 24'(i));
    clks(10);
    mon_en = 1'b0;
    adv_read_req = 1'b0;
    check("stream_pulses", sv_total - base, 6);
    check("stream_full_seen", full_seen, 0);
    check("stream_max_cnt", max_cnt, 1);
    check("stream_cnt_l", dut.buffer_count[0][0], 0);
    check("stream_cnt_r", dut.buffer_count[0][1], 0);
    check("stream_ready", buffer_ready, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
